d_not_ff_arb: RTL

Round-robin arbiter and sequencer that shares one d_not_ff (registered inverter: q <= ~d, 1-cycle latency) among NREQ requesters. Each cycle it grants at most one requester and drives that requester's data bit into the shared flop. Two cycles later it captures the flop output and returns it tagged with the requester ID. Sits between requester logic and a single d_not_ff instance; fully pipelined, one transaction per cycle.

---
 rtl/d_not_ff_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/d_not_ff_arb.sv
// Round-robin arbiter/sequencer sharing one registered inverter among NREQ requesters.
// Optional DFF_ARB_CHK_EN adds a sticky chk_err that flags a wrong flop response.
module d_not_ff_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_d,
    output logic [NREQ-1:0] gnt,
    output logic            ff_d,
    input  logic            ff_q,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
`ifdef DFF_ARB_CHK_EN
    output logic            chk_err,
`endif
    output logic            rsp_data
);

    logic [IDW-1:0]  ptr;
    logic            s1_v, s2_v;
    logic [IDW-1:0]  s1_id, s2_id;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW:0]    cand;
    logic [NREQ-1:0] gnt_nxt;
    logic [IDW-1:0]  ptr_nxt;

    // The requester holding gnt this cycle is masked so a held req is not regranted.
    assign elig = req & ~gnt;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && elig[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
        gnt_nxt = found ? (NREQ'(1) << win) : '0;
        ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gnt       <= '0;
            ff_d      <= 1'b0;
            ptr       <= '0;
            s1_v      <= 1'b0;
            s1_id     <= '0;
            s2_v      <= 1'b0;
            s2_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            gnt  <= gnt_nxt;
            s1_v <= found;
            if (found) begin
                ff_d  <= req_d[win];
                s1_id <= win;
                ptr   <= ptr_nxt;
            end
            s2_v  <= s1_v;
            s2_id <= s1_id;
            // ff_q now reflects the ff_d issued two edges ago.
            rsp_valid <= s2_v;
            if (s2_v) begin
                rsp_id   <= s2_id;
                rsp_data <= ff_q;
            end
        end
    end

`ifdef DFF_ARB_CHK_EN
    logic s1_d, s2_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_d    <= 1'b0;
            s2_d    <= 1'b0;
            chk_err <= 1'b0;
        end else begin
            if (found)
                s1_d <= req_d[win];
            s2_d <= s1_d;
            if (s2_v && (ff_q != ~s2_d))
                chk_err <= 1'b1;
        end
    end
`endif

endmodule
